mux4_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for the 4:1 mux datapath.
- Shares one output channel between four requesters (a, b, c, d), each using a valid/ready handshake.
- Drives the mux select internally and registers the selected data into an output stage.
- Supports bounded bursts, so one requester can hold the channel for several consecutive beats.

---
 rtl/mux4_arb_pkg.sv | 17 +
 rtl/mux4_rr_arbiter_if.sv | 29 ++
 rtl/rr_pick4.sv | 30 +++
 rtl/mux4_rr_arbiter.sv | 135 +++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/mux4_arb_pkg.sv
// Shared types and constants for the 4-requester round-robin arbiter.
package mux4_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0] REQ_A = 2'd0;
    localparam logic [SEL_W-1:0] REQ_B = 2'd1;
    localparam logic [SEL_W-1:0] REQ_C = 2'd2;
    localparam logic [SEL_W-1:0] REQ_D = 2'd3;

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Requester and output handshake bundle for mux4_rr_arbiter.
interface mux4_rr_arbiter_if #(
    parameter int WIDTH = 4
);
    import mux4_arb_pkg::*;

    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    logic [WIDTH-1:0]   req_data_a;
    logic [WIDTH-1:0]   req_data_b;
    logic [WIDTH-1:0]   req_data_c;
    logic [WIDTH-1:0]   req_data_d;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_sel;

    // master is the arbiter's view; slave is the surrounding requesters/sink
    modport master (
        input  req_valid, req_data_a, req_data_b, req_data_c, req_data_d, out_ready,
        output req_ready, out_valid, out_data, out_sel
    );

    modport slave (
        output req_valid, req_data_a, req_data_b, req_data_c, req_data_d, out_ready,
        input  req_ready, out_valid, out_data, out_sel
    );

endinterface

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: first set request after ptr, wrapping mod 4.
module rr_pick4
    import mux4_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [SEL_W-1:0]   idx
);

    logic [SEL_W-1:0] cand;
    logic             found;

    always_comb begin
        // NOTE: every variable gets a default before any branch, otherwise a latch is inferred.
        grant = '0;
        idx   = ptr;
        cand  = ptr;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ptr + SEL_W'(k);
            if (req[cand] && !found) begin
                grant[cand] = 1'b1;
                idx         = cand;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter with bounded bursts feeding a registered 4:1 mux output stage.
// Optional MUX4_RR_ARB_STATS_EN adds per-requester saturating transfer counters.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic clk,
    input  logic rst,
    mux4_rr_arbiter_if.master bus
`ifdef MUX4_RR_ARB_STATS_EN
    ,
    input  logic                stats_clr,
    output logic [NUM_REQ*16-1:0] grant_cnt
`endif
);

    localparam logic [3:0] MAX_B = 4'(MAX_BURST);

    state_t             state, state_n;
    logic [SEL_W-1:0]   ptr, ptr_n;
    logic [3:0]         burst_cnt, burst_n;
    logic               load_en;
    logic               xfer;
    logic [NUM_REQ-1:0] pick_grant, grant_oh, req_ready;
    logic [SEL_W-1:0]   pick_idx, sel;
    logic [WIDTH-1:0]   mux_data;
    logic               out_valid_q;
    logic [WIDTH-1:0]   out_data_q;
    logic [SEL_W-1:0]   out_sel_q;

    rr_pick4 u_pick (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    always_comb begin
        load_en   = !rst && (!out_valid_q || bus.out_ready);
        state_n   = state;
        ptr_n     = ptr;
        burst_n   = burst_cnt;
        grant_oh  = '0;
        sel       = ptr;
        unique case (state)
            IDLE: begin
                grant_oh = pick_grant;
                sel      = pick_idx;
                if (load_en && |pick_grant) begin
                    ptr_n   = pick_idx;
                    burst_n = 4'd1;
                    state_n = (MAX_BURST > 1) ? BURST : IDLE;
                end
            end
            BURST: begin
                // Owner keeps the channel only while it stays valid; a gap forfeits the burst.
                if (load_en) begin
                    if (bus.req_valid[ptr] && burst_cnt < MAX_B) begin
                        grant_oh[ptr] = 1'b1;
                        burst_n       = burst_cnt + 4'd1;
                        if (burst_n == MAX_B) state_n = IDLE;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
        endcase
        req_ready = load_en ? grant_oh : '0;
        xfer      = |(bus.req_valid & req_ready);
    end

    always_comb begin
        unique case (sel)
            REQ_A:   mux_data = bus.req_data_a;
            REQ_B:   mux_data = bus.req_data_b;
            REQ_C:   mux_data = bus.req_data_c;
            default: mux_data = bus.req_data_d;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= REQ_D;
            burst_cnt <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state     <= state_n;
            ptr       <= ptr_n;
            burst_cnt <= burst_n;
        end
    end

    // A new beat overrides a simultaneous drain, keeping out_valid high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= mux_data;
            out_sel_q   <= sel;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;

`ifdef MUX4_RR_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (stats_clr)
                    cnt[i] <= '0;
                else if (bus.req_valid[i] && req_ready[i] && cnt[i] != 16'hFFFF)
                    cnt[i] <= cnt[i] + 16'd1;
            end
        end
    end

    assign grant_cnt = cnt;
`endif

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: one instance with MAX_BURST=1, one with MAX_BURST=4.
// Define MUX4_RR_ARB_STATS_EN to also exercise the transfer counters.
module tb_mux4_rr_arbiter;

    typedef struct {
        logic [3:0] valid;
        logic       rdy;
        logic [3:0] e_ready;
        logic       e_valid;
        logic [3:0] e_data;
        logic [1:0] e_sel;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mux4_rr_arbiter_if #(.WIDTH(4)) if1 ();
    mux4_rr_arbiter_if #(.WIDTH(4)) if4 ();

`ifdef MUX4_RR_ARB_STATS_EN
    logic        clr1, clr4;
    logic [63:0] gc1, gc4;
`endif

    mux4_rr_arbiter #(.WIDTH(4), .MAX_BURST(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .bus       (if1)
`ifdef MUX4_RR_ARB_STATS_EN
        ,
        .stats_clr (clr1),
        .grant_cnt (gc1)
`endif
    );

    mux4_rr_arbiter #(.WIDTH(4), .MAX_BURST(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .bus       (if4)
`ifdef MUX4_RR_ARB_STATS_EN
        ,
        .stats_clr (clr4),
        .grant_cnt (gc4)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] valid, input logic rdy, input logic [3:0] e_ready,
                                input logic e_valid, input logic [3:0] e_data, input logic [1:0] e_sel);
        vec_t v;
        v.valid = valid; v.rdy = rdy; v.e_ready = e_ready;
        v.e_valid = e_valid; v.e_data = e_data; v.e_sel = e_sel;
        return v;
    endfunction

    // Called at a falling edge: drive, check ready before the edge, check outputs after it.
    task automatic step(input int dut, input vec_t v, input string name);
        if (dut == 1) begin
            if1.req_valid = v.valid; if1.out_ready = v.rdy;
        end else begin
            if4.req_valid = v.valid; if4.out_ready = v.rdy;
        end
        #1;
        check({name, " req_ready"}, 32'(dut == 1 ? if1.req_ready : if4.req_ready), 32'(v.e_ready));
        @(posedge clk);
        #1;
        check({name, " out_valid"}, 32'(dut == 1 ? if1.out_valid : if4.out_valid), 32'(v.e_valid));
        check({name, " out_data"},  32'(dut == 1 ? if1.out_data  : if4.out_data),  32'(v.e_data));
        check({name, " out_sel"},   32'(dut == 1 ? if1.out_sel   : if4.out_sel),   32'(v.e_sel));
        @(negedge clk);
    endtask

    // Called at a falling edge; reset must take effect without any clock edge.
    task automatic do_reset();
        rst = 1'b1;
        if4.req_valid = 4'b1111;
        if4.out_ready = 1'b1;
        #1;
        check("rst out_valid", 32'(if4.out_valid), 32'd0);
        check("rst out_data",  32'(if4.out_data),  32'd0);
        check("rst out_sel",   32'(if4.out_sel),   32'd0);
        check("rst req_ready", 32'(if4.req_ready), 32'd0);
        check("rst dut1 out_valid", 32'(if1.out_valid), 32'd0);
        @(negedge clk);
        if4.req_valid = 4'b0000;
        rst = 1'b0;
    endtask

    vec_t  tbl[9];
    vec_t  v;
    logic [1:0] ac_sel[9];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        if1.req_valid = '0; if1.out_ready = 1'b1;
        if1.req_data_a = 4'h1; if1.req_data_b = 4'h2; if1.req_data_c = 4'h3; if1.req_data_d = 4'h4;
        if4.req_valid = '0; if4.out_ready = 1'b1;
        if4.req_data_a = 4'h5; if4.req_data_b = 4'h6; if4.req_data_c = 4'h7; if4.req_data_d = 4'h8;
`ifdef MUX4_RR_ARB_STATS_EN
        clr1 = 1'b0; clr4 = 1'b0;
`endif
        // MAX_BURST=1 rotation, then drain, load while empty, stall, drain
        tbl[0] = mk(4'b1111, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0);
        tbl[1] = mk(4'b1111, 1'b1, 4'b0010, 1'b1, 4'h2, 2'd1);
        tbl[2] = mk(4'b1111, 1'b1, 4'b0100, 1'b1, 4'h3, 2'd2);
        tbl[3] = mk(4'b1111, 1'b1, 4'b1000, 1'b1, 4'h4, 2'd3);
        tbl[4] = mk(4'b1111, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0);
        tbl[5] = mk(4'b0000, 1'b1, 4'b0000, 1'b0, 4'h1, 2'd0);
        tbl[6] = mk(4'b0100, 1'b0, 4'b0100, 1'b1, 4'h3, 2'd2);
        tbl[7] = mk(4'b0100, 1'b0, 4'b0000, 1'b1, 4'h3, 2'd2);
        tbl[8] = mk(4'b0000, 1'b1, 4'b0000, 1'b0, 4'h3, 2'd2);
        ac_sel = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};

        @(negedge clk);
        do_reset();

        for (int i = 0; i < 9; i++)
            step(1, tbl[i], $sformatf("rr1[%0d]", i));
        if1.req_valid = '0;

        // Lone requester b: burst of 4, then re-wins through IDLE without a bubble
        do_reset();
        for (int i = 0; i < 6; i++)
            step(4, mk(4'b0010, 1'b1, 4'b0010, 1'b1, 4'h6, 2'd1), $sformatf("b_only[%0d]", i));
        step(4, mk(4'b0000, 1'b1, 4'b0000, 1'b0, 4'h6, 2'd1), "b_only drain");

        // a and c contend: bursts of 4 alternate
        do_reset();
        for (int i = 0; i < 9; i++) begin
            v = mk(4'b0101, 1'b1, 4'b0001 << ac_sel[i], 1'b1, (ac_sel[i] == 2'd0) ? 4'h5 : 4'h7, ac_sel[i]);
            step(4, v, $sformatf("a_c[%0d]", i));
        end
        // Owner a drops valid mid-burst: no grant this cycle, c wins next
        step(4, mk(4'b0100, 1'b1, 4'b0000, 1'b0, 4'h5, 2'd0), "owner gap");
        step(4, mk(4'b0101, 1'b1, 4'b0100, 1'b1, 4'h7, 2'd2), "after gap");

        // Downstream stall freezes output and burst count
        do_reset();
        if4.req_data_b = 4'hA;
        step(4, mk(4'b1010, 1'b1, 4'b0010, 1'b1, 4'hA, 2'd1), "stall first");
        if4.req_data_b = 4'h3;
        for (int i = 0; i < 3; i++)
            step(4, mk(4'b1010, 1'b0, 4'b0000, 1'b1, 4'hA, 2'd1), $sformatf("stall hold[%0d]", i));
        for (int i = 0; i < 3; i++)
            step(4, mk(4'b1010, 1'b1, 4'b0010, 1'b1, 4'h3, 2'd1), $sformatf("stall resume[%0d]", i));
        step(4, mk(4'b1010, 1'b1, 4'b1000, 1'b1, 4'h8, 2'd3), "stall burst end");
        if4.req_data_b = 4'h6;

        // Reset mid-burst (ptr=2, burst_cnt=2), then a wins first
        do_reset();
        for (int i = 0; i < 2; i++)
            step(4, mk(4'b0100, 1'b1, 4'b0100, 1'b1, 4'h7, 2'd2), $sformatf("pre_rst[%0d]", i));
        do_reset();
        step(4, mk(4'b1111, 1'b1, 4'b0001, 1'b1, 4'h5, 2'd0), "post_rst first");

`ifdef MUX4_RR_ARB_STATS_EN
        do_reset();
        for (int i = 0; i < 10; i++)
            step(4, mk(4'b1000, 1'b1, 4'b1000, 1'b1, 4'h8, 2'd3), $sformatf("stats d[%0d]", i));
        check("stats d count", 32'(gc4[63:48]), 32'd10);
        check("stats a count", 32'(gc4[15:0]),  32'd0);
        clr4 = 1'b1;
        step(4, mk(4'b1000, 1'b1, 4'b1000, 1'b1, 4'h8, 2'd3), "stats clr beat");
        check("stats clr wins", 32'(gc4[63:48]), 32'd0);
        clr4 = 1'b0;
        step(4, mk(4'b1000, 1'b1, 4'b1000, 1'b1, 4'h8, 2'd3), "stats post clr");
        check("stats after clr", 32'(gc4[63:48]), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
